// File: rtl/tt_um_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_pkg
//  Description : Shared types and constants for the ternary weight readback
//                block: FSM state encoding, ternary weight codes, config word
//                field positions, the header marker bit and small config
//                decode helpers.
//  Macro       : TT_READBACK_HDR_EN (consumed by tt_um_weight_readback)
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_um_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // Ternary weight codes as stored by the load block.
    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] NEG  = 2'b11;
    localparam logic [1:0] ZERO = 2'b00;

    // Config word layout: [6:3] = in_len-1, [2:0] = out_len-1.
    localparam int IN_LEN_MSB  = 6;
    localparam int IN_LEN_LSB  = 3;
    localparam int OUT_LEN_MSB = 2;
    localparam int OUT_LEN_LSB = 0;

    // Marker bit that distinguishes the header byte from weight bytes.
    localparam logic HDR_MSB = 1'b1;

    // Active column count, 1..16.
    function automatic logic [4:0] cfg_in_len(input logic [6:0] cfg);
        return {1'b0, cfg[IN_LEN_MSB:IN_LEN_LSB]} + 5'd1;
    endfunction

    // Index of the final 4-column group: floor((in_len-1)/4), which is simply
    // the top two bits of the in_len-1 field.
    function automatic logic [1:0] cfg_last_grp(input logic [6:0] cfg);
        return cfg[IN_LEN_MSB -: 2];
    endfunction

    // Index of the final row: out_len-1.
    function automatic logic [2:0] cfg_last_row(input logic [6:0] cfg);
        return cfg[OUT_LEN_MSB:OUT_LEN_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_um_byte_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_byte_pack
//  Description : Combinational packer. Selects one row of the weight store
//                and gathers the four weights of column group grp into one
//                byte, lane k in bits [2k+1:2k]. Columns at or beyond in_len
//                are forced to the zero code.
//  Ports       : weights_i - flattened weight store
//                row_i     - row index
//                grp_i     - 4-column group index
//                in_len_i  - active column count (1..MAX_IN_LEN)
//                byte_o    - packed byte
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_byte_pack
    import tt_um_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights_i,
    input  logic [$clog2(MAX_OUT_LEN)-1:0]      row_i,
    input  logic [$clog2(MAX_IN_LEN/4)-1:0]     grp_i,
    input  logic [$clog2(MAX_IN_LEN):0]         in_len_i,
    output logic [7:0]                          byte_o
);

    logic [2*MAX_IN_LEN-1:0] w_row;

    assign w_row = weights_i[row_i * (2*MAX_IN_LEN) +: 2*MAX_IN_LEN];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] c_LANE = 2'(k);

        logic [$clog2(MAX_IN_LEN)-1:0] w_col;

        assign w_col = {grp_i, c_LANE};
        assign byte_o[2*k +: 2] = ({1'b0, w_col} < in_len_i) ? w_row[2*w_col +: 2] : ZERO;
    end

endmodule

`default_nettype wire

// File: rtl/tt_um_weight_readback.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_weight_readback
//  Description : Streams the active sub-matrix of the ternary weight store as
//                packed bytes (four 2-bit weights per byte, row-major) over a
//                valid/ready byte interface. All outputs are registered.
//  Macro       : TT_READBACK_HDR_EN - when defined, a header byte
//                {1'b1, cfg} precedes the weight bytes.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                ena             - block enable; low aborts a transfer
//                start           - readback request (IDLE only)
//                ui_param        - config word, latched on start
//                ui_weights      - weight store, read live during transfer
//                uo_data/valid/ready/last - byte stream handshake
//                uo_busy         - transfer in progress
//                uo_done         - one-cycle pulse after the final accept
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_weight_readback
    import tt_um_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic                                start,
    input  logic [6:0]                          ui_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    output logic [7:0]                          uo_data,
    output logic                                uo_valid,
    input  logic                                uo_ready,
    output logic                                uo_last,
    output logic                                uo_busy,
    output logic                                uo_done
);

    localparam int ROW_W = $clog2(MAX_OUT_LEN);
    localparam int GRP_W = $clog2(MAX_IN_LEN/4);
    localparam int LEN_W = $clog2(MAX_IN_LEN) + 1;

    state_e             state_q, state_d;
    logic [6:0]         cfg_q,   cfg_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [GRP_W-1:0]   grp_q,   grp_d;
    logic [7:0]         data_q,  data_d;
    logic               valid_q, valid_d;
    logic               last_q,  last_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               w_load_w;
    logic               w_load_hdr;
    logic               w_clr;
    logic [LEN_W-1:0]   w_in_len;
    logic [7:0]         w_pack_byte;

    // The packer looks at the *next* row/group/config so the byte lands in
    // the output register on the same edge that advances the counters.
    assign w_in_len = LEN_W'(cfg_in_len(cfg_d));

    tt_um_byte_pack #(
        .MAX_IN_LEN  (MAX_IN_LEN),
        .MAX_OUT_LEN (MAX_OUT_LEN)
    ) u_byte_pack (
        .weights_i (ui_weights),
        .row_i     (row_d),
        .grp_i     (grp_d),
        .in_len_i  (w_in_len),
        .byte_o    (w_pack_byte)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        row_d      = row_q;
        grp_d      = grp_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        w_load_w   = 1'b0;
        w_load_hdr = 1'b0;
        w_clr      = 1'b0;

        if (!ena && state_q != IDLE) begin
            // Abort: silent return to IDLE, no done pulse.
            state_d = IDLE;
            row_d   = '0;
            grp_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            w_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && ena) begin
                        cfg_d   = ui_param;
                        row_d   = '0;
                        grp_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
`ifdef TT_READBACK_HDR_EN
                        state_d    = HDR;
                        last_d     = 1'b0;
                        w_load_hdr = 1'b1;
`else
                        state_d  = SEND;
                        w_load_w = 1'b1;
`endif
                    end
                end
                HDR: begin
                    if (uo_ready) begin
                        state_d  = SEND;
                        w_load_w = 1'b1;
                    end
                end
                SEND: begin
                    if (uo_ready) begin
                        if (last_q) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            w_clr   = 1'b1;
                        end else begin
                            if (grp_q == GRP_W'(cfg_last_grp(cfg_q))) begin
                                grp_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                grp_d = grp_q + GRP_W'(1);
                            end
                            w_load_w = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    row_d   = '0;
                    grp_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (w_load_w) begin
            last_d = (row_d == ROW_W'(cfg_last_row(cfg_d))) &&
                     (grp_d == GRP_W'(cfg_last_grp(cfg_d)));
        end
    end

    always_comb begin
        data_d = data_q;
        if (w_clr) begin
            data_d = '0;
        end else if (w_load_hdr) begin
            data_d = {HDR_MSB, cfg_d};
        end else if (w_load_w) begin
            data_d = w_pack_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            row_q   <= '0;
            grp_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            row_q   <= row_d;
            grp_q   <= grp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uo_data  = data_q;
    assign uo_valid = valid_q;
    assign uo_last  = last_q;
    assign uo_busy  = busy_q;
    assign uo_done  = done_q;

endmodule

`default_nettype wire
